microcontrolador_pwm_saida: RTL

Avalon-MM slave output peripheral for the Nios II microcontroller subsystem: the CPU writes registers over the system bus and the block drives an 8-bit `out_port` to the FPGA pins. Each pin carries either a static CPU-written level or a shared PWM waveform selected by a mask. Period and duty writes are double-buffered and take effect only at a PWM period boundary, giving glitch-free updates. This is the write-side, pin-driving counterpart of the read-only input-pin peripheral.

---
 rtl/microcontrolador_pwm_saida_pkg.sv | 31 +++
 rtl/microcontrolador_pwm_saida_if.sv | 18 +
 rtl/microcontrolador_pwm_saida_contador.sv | 41 ++++
 rtl/microcontrolador_pwm_saida.sv | 104 ++++++++++
 4 files changed

// File: rtl/microcontrolador_pwm_saida_pkg.sv
// Shared definitions for the PWM/static output peripheral: register map,
// control-field positions and the packed CTRL register layout.
package microcontrolador_pwm_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_INV      = 1;
    localparam int CTRL_MASK_LSB = 8;
    localparam int CTRL_MASK_MSB = 15;

    typedef struct packed {
        logic [7:0] mask;
        logic       inv;
        logic       en;
    } ctrl_t;

    // Places the CTRL fields at their bus positions; unused bits read as zero.
    function automatic logic [31:0] ctrl_to_word(ctrl_t c);
        logic [31:0] word;
        word                              = 32'h0000_0000;
        word[CTRL_MASK_MSB:CTRL_MASK_LSB] = c.mask;
        word[CTRL_INV]                    = c.inv;
        word[CTRL_EN]                     = c.en;
        return word;
    endfunction

endpackage

// File: rtl/microcontrolador_pwm_saida_if.sv
// Avalon-MM slave bus bundle for the output peripheral (no wait states).
interface microcontrolador_pwm_saida_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/microcontrolador_pwm_saida_contador.sv
// PWM counter with double-buffered period/duty. The active copies follow
// the pending ones continuously while disabled and only at the period
// boundary while running, so a waveform period is never cut short.
module microcontrolador_pwm_contador #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] pend_period,
    input  logic [WIDTH-1:0] pend_duty,
    output logic             pwm_raw
);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] period_act_r;
    logic [WIDTH-1:0] duty_act_r;

    // Counter advance/wrap and shadow-register reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= {WIDTH{1'b0}};
            period_act_r <= {WIDTH{1'b0}};
            duty_act_r   <= {WIDTH{1'b0}};
        end else if (!en) begin
            cnt_r        <= {WIDTH{1'b0}};
            period_act_r <= pend_period;
            duty_act_r   <= pend_duty;
        end else if (cnt_r == period_act_r) begin
            cnt_r        <= {WIDTH{1'b0}};
            period_act_r <= pend_period;
            duty_act_r   <= pend_duty;
        end else begin
            cnt_r        <= cnt_r + WIDTH'(1);
        end
    end

    // Duty 0 never matches, duty beyond the period always matches.
    assign pwm_raw = (cnt_r < duty_act_r);

endmodule

// File: rtl/microcontrolador_pwm_saida.sv
// Avalon-MM output peripheral: CPU-written static levels and a shared,
// mask-selected PWM waveform drive an 8-bit registered pin bus.
module microcontrolador_pwm_saida
    import microcontrolador_pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    microcontrolador_pwm_saida_if.slave   bus,
    output logic [7:0]                    out_port
);

    logic [7:0]       data_r;
    logic [WIDTH-1:0] period_pend_r;
    logic [WIDTH-1:0] duty_pend_r;
    ctrl_t            ctrl_r;

    logic             wr_en_s;
    logic [31:0]      rd_data_s;
    logic             pwm_raw_s;
    logic             pwm_s;
    logic [7:0]       next_out_s;
    logic             unused_wdata_s;

    assign wr_en_s        = bus.chipselect & ~bus.write_n;
    assign unused_wdata_s = ^bus.writedata;

    // Register file: only the defined low bits of each write are kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r        <= 8'h00;
            period_pend_r <= {WIDTH{1'b0}};
            duty_pend_r   <= {WIDTH{1'b0}};
            ctrl_r        <= '{mask: 8'h00, inv: 1'b0, en: 1'b0};
        end else if (wr_en_s) begin
            case (bus.address)
                ADDR_DATA:   data_r        <= bus.writedata[7:0];
                ADDR_PERIOD: period_pend_r <= bus.writedata[WIDTH-1:0];
                ADDR_DUTY:   duty_pend_r   <= bus.writedata[WIDTH-1:0];
                ADDR_CTRL: begin
                    ctrl_r.mask <= bus.writedata[CTRL_MASK_MSB:CTRL_MASK_LSB];
                    ctrl_r.inv  <= bus.writedata[CTRL_INV];
                    ctrl_r.en   <= bus.writedata[CTRL_EN];
                end
                default: ;
            endcase
        end
    end

    // Read mux: pending values are returned, zero-extended to 32 bits.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (bus.address)
            ADDR_DATA:   rd_data_s[7:0]       = data_r;
            ADDR_PERIOD: rd_data_s[WIDTH-1:0] = period_pend_r;
            ADDR_DUTY:   rd_data_s[WIDTH-1:0] = duty_pend_r;
            ADDR_CTRL:   rd_data_s            = ctrl_to_word(ctrl_r);
            default:     rd_data_s            = 32'h0000_0000;
        endcase
    end

    // Read data is reloaded every cycle; reads have no side effects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 32'h0000_0000;
        end else begin
            bus.readdata <= rd_data_s;
        end
    end

    microcontrolador_pwm_contador #(.WIDTH(WIDTH)) u_contador (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (ctrl_r.en),
        .pend_period (period_pend_r),
        .pend_duty   (duty_pend_r),
        .pwm_raw     (pwm_raw_s)
    );

    assign pwm_s = pwm_raw_s ^ ctrl_r.inv;

    // Per-pin select between the shared waveform and the static level.
    always_comb begin
        next_out_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (ctrl_r.en && ctrl_r.mask[i]) begin
                next_out_s[i] = pwm_s;
            end else begin
                next_out_s[i] = data_r[i];
            end
        end
    end

    // Pin output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= 8'h00;
        end else begin
            out_port <= next_out_s;
        end
    end

endmodule
